// File: rtl/fifo_read_ctrl.sv
// Read-side controller of an asynchronous FIFO: synchronizer, pointers, empty flag.
// Define FIFO_READ_CTRL_AE_EN to add the registered rempty_almost output.
module fifo_read_ctrl #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int ADDR     = 5,
    parameter int AE_LEVEL = 4
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             rinc,
    input  logic [ADDR:0]    wptr_gray,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [ADDR-1:0]  raddr,
    output logic [ADDR:0]    rptr_gray,
    output logic             rempty,
    output logic [WIDTH-1:0] rdata,
`ifdef FIFO_READ_CTRL_AE_EN
    output logic             rempty_almost,
`endif
    output logic             rvalid
);

    if (DEPTH != (1 << ADDR)) begin : g_depth_chk
        $error("fifo_read_ctrl: DEPTH must equal 2**ADDR");
    end

    logic [ADDR:0]    r_rq1;
    logic [ADDR:0]    r_rq2;
    logic [ADDR:0]    r_rbin;
    logic [ADDR:0]    r_rgray;
    logic             r_rempty;
    logic [WIDTH-1:0] r_rdata;
    logic             r_rvalid;

    logic             w_accept;
    logic [ADDR:0]    w_rbin_next;
    logic [ADDR:0]    w_rgray_next;

    assign w_accept     = rinc & ~r_rempty;
    assign w_rbin_next  = r_rbin + {{ADDR{1'b0}}, w_accept};
    assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

    // Empty compares the next pointer so the last read sets empty on its own edge.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_rq1    <= '0;
            r_rq2    <= '0;
            r_rbin   <= '0;
            r_rgray  <= '0;
            r_rempty <= 1'b1;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rq1    <= wptr_gray;
            r_rq2    <= r_rq1;
            r_rbin   <= w_rbin_next;
            r_rgray  <= w_rgray_next;
            r_rempty <= (w_rgray_next == r_rq2);
            r_rvalid <= w_accept;
            if (w_accept) begin
                r_rdata <= mem_rdata;
            end
        end
    end

`ifdef FIFO_READ_CTRL_AE_EN
    localparam logic [ADDR:0] AE_LVL = AE_LEVEL[ADDR:0];

    logic [ADDR:0] w_wbin_s;
    logic [ADDR:0] w_fill;
    logic          r_ae;

    always_comb begin
        w_wbin_s = '0;
        for (int i = 0; i <= ADDR; i++) begin
            w_wbin_s[i] = ^(r_rq2 >> i);
        end
    end

    assign w_fill = w_wbin_s - w_rbin_next;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_ae <= 1'b1;
        end else begin
            r_ae <= (w_fill <= AE_LVL);
        end
    end

    assign rempty_almost = r_ae;
`endif

    assign raddr     = r_rbin[ADDR-1:0];
    assign rptr_gray = r_rgray;
    assign rempty    = r_rempty;
    assign rdata     = r_rdata;
    assign rvalid    = r_rvalid;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl: stimulus pushes expected words,
// a negedge monitor pops them whenever rvalid is seen.
module tb_fifo_read_ctrl;

    logic       clk = 1'b0;
    logic       reset_b;
    logic       rinc;
    logic [5:0] wptr_gray;
    logic [7:0] mem_rdata;
    logic [4:0] raddr;
    logic [5:0] rptr_gray;
    logic       rempty;
    logic [7:0] rdata;
    logic       rvalid;
`ifdef FIFO_READ_CTRL_AE_EN
    logic       rempty_almost;
`endif

    logic [7:0] mem [32];
    logic [7:0] sb_q[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[raddr];

    fifo_read_ctrl dut (
        .clk(clk),
        .reset_b(reset_b),
        .rinc(rinc),
        .wptr_gray(wptr_gray),
        .mem_rdata(mem_rdata),
        .raddr(raddr),
        .rptr_gray(rptr_gray),
        .rempty(rempty),
        .rdata(rdata),
`ifdef FIFO_READ_CTRL_AE_EN
        .rempty_almost(rempty_almost),
`endif
        .rvalid(rvalid)
    );

    function automatic logic [5:0] gray(input int v);
        logic [5:0] b;
        b = v[5:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL rvalid_unexpected: got rdata=%0h expected no strobe",
                         rdata);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                if (rdata !== e) begin
                    bad++;
                    $display("FAIL rdata: got %0h expected %0h", rdata, e);
                end
            end
        end
    end

    task automatic do_reset(input int n);
        reset_b   = 1'b0;
        wptr_gray = '0;
        repeat (n) @(posedge clk);
        #1 reset_b = 1'b1;
    endtask

    task automatic advance(input int from, input int to);
        for (int w = from + 1; w <= to; w++) begin
            @(posedge clk);
            #1 wptr_gray = gray(w);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Issue n accepted reads starting at read index base.
    task automatic reads(input int base, input int n);
        rinc = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rd_addr", 32'(raddr), 32'((base + i) % 32));
            chk("rd_nonempty", 32'(rempty), 32'd0);
            sb_q.push_back(mem[(base + i) % 32]);
            @(posedge clk);
            #1;
        end
        rinc = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 29) ^ 8'h5A;
        mem[0]    = 8'hA5;
        rinc      = 1'b1;
        wptr_gray = '0;
        reset_b   = 1'b0;

        // Reset held for two edges with rinc asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rempty", 32'(rempty), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_rptr", 32'(rptr_gray), 32'd0);
        @(posedge clk);
        #1 reset_b = 1'b1;
        rinc = 1'b0;

        // Single word: empty must not fall before the synchronizer.
        @(posedge clk);
        #1 wptr_gray = 6'b000001;
        @(posedge clk);
        #1 chk("sync_edge1_empty", 32'(rempty), 32'd1);
        n = 1;
        while (rempty === 1'b1 && n < 6) begin
            @(posedge clk);
            #1 n++;
        end
        total++;
        if (n < 2 || n > 3) begin
            bad++;
            $display("FAIL empty_fall_latency: got %0d edges expected 2..3", n);
        end
        rinc = 1'b1;
        sb_q.push_back(8'hA5);
        @(posedge clk);
        #1 rinc = 1'b0;
        @(negedge clk);
        chk("single_rvalid", 32'(rvalid), 32'd1);
        chk("single_rempty", 32'(rempty), 32'd1);
        chk("single_rptr", 32'(rptr_gray), 32'h01);

        // Underflow: rinc while empty is ignored.
        rinc = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("uf_raddr", 32'(raddr), 32'd1);
            chk("uf_rptr", 32'(rptr_gray), 32'h01);
            chk("uf_rvalid", 32'(rvalid), 32'd0);
        end
        rinc = 1'b0;

        // Wrap: 40 words through a 32-entry memory.
        @(posedge clk);
        do_reset(1);
        advance(0, 40);
        reads(0, 40);
        @(negedge clk);
        chk("wrap_rempty", 32'(rempty), 32'd1);
        chk("wrap_rptr", 32'(rptr_gray), 32'h3C);
        chk("wrap_raddr", 32'(raddr), 32'd8);

`ifdef FIFO_READ_CTRL_AE_EN
        // Almost-empty with 6 words, then 2 reads leaves 4.
        @(posedge clk);
        do_reset(1);
        @(negedge clk);
        chk("ae_reset", 32'(rempty_almost), 32'd1);
        advance(0, 6);
        chk("ae_six", 32'(rempty_almost), 32'd0);
        reads(0, 2);
        chk("ae_four", 32'(rempty_almost), 32'd1);
        chk("ae_rempty", 32'(rempty), 32'd0);
`endif

        // Reset mid-stream after 3 of 10 reads.
        @(posedge clk);
        do_reset(1);
        advance(0, 10);
        reads(0, 3);
        rinc    = 1'b1;
        reset_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_raddr", 32'(raddr), 32'd0);
        chk("mid_rptr", 32'(rptr_gray), 32'd0);
        chk("mid_rempty", 32'(rempty), 32'd1);
        chk("mid_rvalid", 32'(rvalid), 32'd0);
        rinc    = 1'b0;
        #1 reset_b = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_read_ctrl.md
FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width.
REQ-002 SHALL have parameter DEPTH, default 32, memory entries (power of two).
REQ-003 SHALL have parameter ADDR, default 5, log2(DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, default 4, almost-empty threshold in words.
REQ-005 SHALL have port clk, input, 1, read-domain clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_b, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port rinc, input, 1, read request.
REQ-008 SHALL have port wptr_gray, input, ADDR+1, Gray write pointer, asynchronous to clk.
REQ-009 SHALL have port mem_rdata, input, WIDTH, combinational memory output at raddr.
REQ-010 SHALL have port raddr, output, ADDR, memory read address.
REQ-011 SHALL have port rptr_gray, output, ADDR+1, registered Gray read pointer for the write side.
REQ-012 SHALL have port rempty, output, 1, registered empty flag.
REQ-013 SHALL have port rdata, output, WIDTH, registered read data.
REQ-014 SHALL have port rvalid, output, 1, one-cycle strobe qualifying rdata.
REQ-015 SHALL have port rempty_almost, output, 1, present only when FIFO_READ_CTRL_AE_EN is defined.

Function
REQ-016 SHALL pass wptr_gray through a two-flop synchronizer (rq1, rq2) before any use.
REQ-017 SHALL keep an (ADDR+1)-bit binary read pointer rbin; raddr = rbin[ADDR-1:0].
REQ-018 SHALL accept a read in a cycle iff rinc=1 and rempty=0; rinc while rempty=1 is ignored, with no pointer change and no rvalid.
REQ-019 SHALL compute rbin_next = rbin + accepted and rgray_next = (rbin_next>>1) ^ rbin_next, registering both, so rptr_gray changes by at most one bit per cycle.
REQ-020 SHALL register rempty = (rgray_next == rq2); empty is asserted in the same edge as the last read is accepted.
REQ-021 SHALL wrap rbin modulo 2^(ADDR+1); raddr wraps from DEPTH-1 to 0 without a gap.
REQ-022 SHALL, on an accepted read, load rdata with mem_rdata and assert rvalid for exactly one cycle: read latency of one clock from the accepting edge.
REQ-023 SHALL hold rdata unchanged when no read is accepted; rvalid=0 then.
REQ-024 SHALL deassert rempty no earlier than two clk edges after wptr_gray changes (synchronizer latency); pessimistic empty is permitted, false non-empty is not.
REQ-025 SHALL process back-to-back reads at one word per cycle while rempty=0.

Reset
REQ-026 SHALL, when reset_b=0 at a clk edge, clear rq1, rq2, rbin, rptr_gray, rdata, rvalid to 0 and set rempty=1 (and rempty_almost=1 if present).
REQ-027 SHALL give reset priority over rinc; a read requested during reset is dropped.
REQ-028 SHALL, on reset mid-stream, leave the memory contents untouched; pointers restart at 0.

Configuration
REQ-029 SHALL, with FIFO_READ_CTRL_AE_EN defined, convert rq2 to binary wbin_s and register rempty_almost = ((wbin_s - rbin_next) mod 2^(ADDR+1)) <= AE_LEVEL.
REQ-030 SHALL, without FIFO_READ_CTRL_AE_EN, omit the rempty_almost port, the Gray-to-binary logic, and the subtractor; all other behaviour is identical.

Verification
REQ-031 SHALL check reset: reset_b=0 for 2 clk with rinc=1 -> rempty=1, rvalid=0, raddr=0, rptr_gray=0.
REQ-032 SHALL check a single word: wptr_gray 0->1 -> rempty falls within 2-3 clk; rinc=1 for one cycle with mem_rdata=8'hA5 -> next cycle rdata=8'hA5, rvalid=1, rempty=1, rptr_gray=6'b000001.
REQ-033 SHALL check underflow: rempty=1 and rinc held 5 cycles -> raddr, rptr_gray unchanged, rvalid=0 throughout.
REQ-034 SHALL check wrap: write pointer advanced by 40 words, 40 consecutive reads -> raddr runs 0..31 and then 0..7, rptr_gray is the Gray code of 40, and rempty=1 after the 40th read.
REQ-035 SHALL check almost-empty (macro defined, AE_LEVEL=4): 6 words available -> rempty_almost=0; after 2 reads -> rempty_almost=1 and rempty=0.
REQ-036 SHALL check reset mid-stream: reset_b=0 after 3 of 10 reads -> pointers 0, rempty=1, rvalid=0 on the next edge.
